// File: rtl/fifo_drain.sv
// Read-side controller for the 8-entry byte FIFO: absorbs the FIFO's registered
// read latency and re-presents bytes on a valid/ready stream with burst framing.
module fifo_drain #(
    parameter int DW        = 8,
    parameter int BURST_LEN = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          fifo_empty,
    output logic          fifo_r_en,
    input  logic [DW-1:0] fifo_data,
    input  logic          fifo_valid,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic [15:0]   byte_cnt,
    output logic          proto_err
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN - 1);

    logic [DW-1:0] data_q [4];
    logic [3:0]    last_q;

    logic [1:0]    wr_ptr_q, wr_ptr_d;
    logic [1:0]    rd_ptr_q, rd_ptr_d;
    logic [2:0]    occ_q, occ_d;
    logic          infl_q, infl_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [15:0]   byte_cnt_q, byte_cnt_d;
    logic          proto_err_q, proto_err_d;

    logic          capture;
    logic          drain;
    logic          cap_last;

    // Buffer space is reserved at issue time, so a capture can never overflow.
    always_comb begin
        fifo_r_en = en & ~fifo_empty & ~rst
                    & (({1'b0, occ_q} + {3'b000, infl_q}) < 4'd4);
        capture   = fifo_valid & infl_q;
        cap_last  = (beat_q == BEAT_MAX);
        m_valid   = (occ_q != 3'd0) & ~rst;
        drain     = m_valid & m_ready;
        m_data    = data_q[rd_ptr_q];
        m_last    = last_q[rd_ptr_q] & m_valid;
        byte_cnt  = byte_cnt_q;
        proto_err = proto_err_q;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        beat_d      = beat_q;
        byte_cnt_d  = byte_cnt_q;
        proto_err_d = proto_err_q;

        if (fifo_r_en) begin
            infl_d = 1'b1;
        end else if (fifo_valid) begin
            infl_d = 1'b0;
        end else begin
            infl_d = infl_q;
        end

        if (capture) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
            beat_d   = cap_last ? '0 : beat_q + BW'(1);
        end
        if (fifo_valid && !infl_q) begin
            proto_err_d = 1'b1;
        end
        if (drain) begin
            rd_ptr_d   = rd_ptr_q + 2'd1;
            byte_cnt_d = byte_cnt_q + 16'd1;
        end

        case ({capture, drain})
            2'b10:   occ_d = occ_q + 3'd1;
            2'b01:   occ_d = occ_q - 3'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            infl_q      <= 1'b0;
            beat_q      <= '0;
            byte_cnt_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            infl_q      <= infl_d;
            beat_q      <= beat_d;
            byte_cnt_q  <= byte_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (capture) begin
            data_q[wr_ptr_q] <= fifo_data;
            last_q[wr_ptr_q] <= cap_last;
        end
    end

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: behavioural 8-entry FIFO with one-cycle read
// latency, a stream scoreboard, a per-cycle vector table and corner sequences.
module tb_fifo_drain;

    localparam int BL = 4;

    logic        clk;
    logic        rst;
    logic        en;
    logic        fifo_empty;
    logic        fifo_r_en;
    logic [7:0]  fifo_data;
    logic        fifo_valid;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [15:0] byte_cnt;
    logic        proto_err;

    fifo_drain #(.DW(8), .BURST_LEN(BL)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (fifo_r_en),
        .fifo_data  (fifo_data),
        .fifo_valid (fifo_valid),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .byte_cnt   (byte_cnt),
        .proto_err  (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic        rdy;
        logic        r_en;
        logic        mv;
        logic [7:0]  md;
        logic        ml;
        logic [15:0] bc;
    } vec_t;

    vec_t vecs [11];

    int tests    = 0;
    int failures = 0;

    logic [7:0] fq [$];
    logic [7:0] sq [$];
    int   out_idx  = 0;
    int   acc_cnt  = 0;
    int   last_cnt = 0;
    int   rcount   = 0;
    logic orphan   = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic prev_last = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic settle(input logic push, input logic [7:0] d);
        if (push && fq.size() < 8) begin
            fq.push_back(d);
            sq.push_back(d);
        end
        fifo_empty = (fq.size() == 0);
        #1;
        if (fifo_r_en) rcount++;
    endtask

    task automatic advance();
        logic       rd;
        logic [7:0] exp_d;
        if (!rst && prev_stall) begin
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_data", 32'(m_data), 32'(prev_data));
            check("hold_last", 32'(m_last), 32'(prev_last));
        end
        if (fifo_r_en) check("rd_nonempty", 32'(fifo_empty), 32'd0);
        if (!rst && m_valid && m_ready) begin
            if (sq.size() == 0) begin
                check("sb_extra_byte", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
                exp_d = sq.pop_front();
                check("sb_data", 32'(m_data), 32'(exp_d));
                check("sb_last", 32'(m_last), 32'((out_idx % BL) == BL - 1));
            end
            out_idx++;
            acc_cnt++;
            if (m_last) last_cnt++;
        end
        prev_stall = !rst && m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        rd = fifo_r_en;
        @(posedge clk);
        #1;
        if (rst) begin
            fq.delete();
            sq.delete();
            out_idx    = 0;
            fifo_valid = 1'b0;
            prev_stall = 1'b0;
        end else if (orphan) begin
            fifo_valid = 1'b1;
            fifo_data  = 8'hEE;
            orphan     = 1'b0;
        end else if (rd) begin
            fifo_data  = fq.pop_front();
            fifo_valid = 1'b1;
        end else begin
            fifo_valid = 1'b0;
        end
        fifo_empty = (fq.size() == 0);
        @(negedge clk);
    endtask

    task automatic step(input logic push, input logic [7:0] d);
        settle(push, d);
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 8'h00);
        rst = 1'b0;
    endtask

    initial begin
        //           en    rdy   r_en  mv    md     ml    bc
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 16'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 16'd1};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 16'd2};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 16'd3};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 1'b0, 16'd4};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 16'd5};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h06, 1'b0, 16'd6};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 16'd7};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd8};

        rst = 1'b1; en = 1'b0; m_ready = 1'b0;
        fifo_empty = 1'b1; fifo_valid = 1'b0; fifo_data = '0;
        @(negedge clk);
        do_reset();

        // Reset state
        settle(1'b0, 8'h00);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        check("rst_r_en", 32'(fifo_r_en), 32'd0);
        advance();

        // Streaming: preload 0x00..0x07 with en low, then walk the vector table
        for (int i = 0; i < 8; i++) step(1'b1, 8'(i));
        for (int c = 0; c < 11; c++) begin
            en = vecs[c].en;
            m_ready = vecs[c].rdy;
            settle(1'b0, 8'h00);
            check($sformatf("vec%0d_r_en", c), 32'(fifo_r_en), 32'(vecs[c].r_en));
            check($sformatf("vec%0d_m_valid", c), 32'(m_valid), 32'(vecs[c].mv));
            if (vecs[c].mv) begin
                check($sformatf("vec%0d_m_data", c), 32'(m_data), 32'(vecs[c].md));
                check($sformatf("vec%0d_m_last", c), 32'(m_last), 32'(vecs[c].ml));
            end
            check($sformatf("vec%0d_byte_cnt", c), 32'(byte_cnt), 32'(vecs[c].bc));
            advance();
        end

        // Burst marking: 10 bytes give m_last on the 4th and 8th only
        do_reset();
        en = 1'b1; m_ready = 1'b1; acc_cnt = 0; last_cnt = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h10 + i));
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00);
        check("burst_accepted", 32'(acc_cnt), 32'd10);
        check("burst_lasts", 32'(last_cnt), 32'd2);
        check("burst_byte_cnt", 32'(byte_cnt), 32'd10);
        for (int i = 0; i < 2; i++) step(1'b1, 8'(8'h40 + i));
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00);
        check("burst_resume_last", 32'(last_cnt), 32'd3);

        // Backpressure: full FIFO, m_ready low for 20 cycles, then release
        do_reset();
        en = 1'b0; m_ready = 1'b0; acc_cnt = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h80 + i));
        en = 1'b1; rcount = 0;
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00);
        check("bp_read_pulses", 32'(rcount), 32'd4);
        check("bp_fifo_left", 32'(fq.size()), 32'd4);
        m_ready = 1'b1;
        begin
            int gaps;
            gaps = 0;
            for (int i = 0; i < 8; i++) begin
                settle(1'b0, 8'h00);
                if (!m_valid) gaps++;
                advance();
            end
            check("bp_no_gaps", 32'(gaps), 32'd0);
        end
        step(1'b0, 8'h00);
        check("bp_accepted", 32'(acc_cnt), 32'd8);
        check("bp_byte_cnt", 32'(byte_cnt), 32'd8);

        // Empty boundary: one byte every 3 cycles, 2-cycle read-to-stream latency
        do_reset();
        en = 1'b1; m_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle(1'b1, 8'(8'hA0 + k));
            check("eb_read_issue", 32'(fifo_r_en), 32'd1);
            advance();
            settle(1'b0, 8'h00);
            check("eb_read_idle", 32'(fifo_r_en), 32'd0);
            check("eb_not_yet", 32'(m_valid), 32'd0);
            advance();
            settle(1'b0, 8'h00);
            check("eb_valid_t2", 32'(m_valid), 32'd1);
            check("eb_data_t2", 32'(m_data), 32'(8'hA0 + k));
            advance();
        end

        // en gating mid-burst: in-flight byte lands, burst position kept
        do_reset();
        en = 1'b0; m_ready = 1'b1; acc_cnt = 0; last_cnt = 0;
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i));
        en = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
        en = 1'b0; rcount = 0;
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00);
        check("en_no_reads", 32'(rcount), 32'd0);
        check("en_inflight_done", 32'(acc_cnt), 32'd3);
        en = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00);
        check("en_all_bytes", 32'(acc_cnt), 32'd6);
        check("en_burst_kept", 32'(last_cnt), 32'd1);
        check("en_byte_cnt", 32'(byte_cnt), 32'd6);

        // Reset with three bytes buffered
        m_ready = 1'b0; en = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hD0 + i));
        en = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
        en = 1'b0;
        for (int i = 0; i < 2; i++) step(1'b0, 8'h00);
        settle(1'b0, 8'h00);
        check("occ3_valid", 32'(m_valid), 32'd1);
        advance();
        en = 1'b1; rst = 1'b1;
        settle(1'b0, 8'h00);
        check("inrst_r_en", 32'(fifo_r_en), 32'd0);
        check("inrst_m_valid", 32'(m_valid), 32'd0);
        check("inrst_m_last", 32'(m_last), 32'd0);
        advance();
        rst = 1'b0; en = 1'b0;
        settle(1'b0, 8'h00);
        check("postrst_m_valid", 32'(m_valid), 32'd0);
        check("postrst_byte_cnt", 32'(byte_cnt), 32'd0);
        check("postrst_proto_err", 32'(proto_err), 32'd0);
        advance();

        // Orphan fifo_valid: dropped, proto_err sticky until reset
        orphan = 1'b1;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            settle(1'b0, 8'h00);
            check("orphan_err", 32'(proto_err), 32'd1);
            check("orphan_dropped", 32'(m_valid), 32'd0);
            advance();
        end
        do_reset();
        settle(1'b0, 8'h00);
        check("orphan_cleared", 32'(proto_err), 32'd0);
        advance();

        // Counter wrap: stream 0xFFFE bytes, then 3 more
        en = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 65534; i++) step(1'b1, 8'(i));
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00);
        check("wrap_pre", 32'(byte_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h55 + i));
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00);
        check("wrap_post", 32'(byte_cnt), 32'h0001);
        check("wrap_sb_empty", 32'(sq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
